// File: rtl/fpu_conv_arbiter.sv
// fpu_conv_arbiter: round-robin arbiter that shares one int/float conversion
// unit among NREQ requesters. The winner's operand is latched and presented to
// the unit with the order/accepted/done handshake. The result is captured and
// returned to the winner with a one-cycle done pulse.
module fpu_conv_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_order,
    input  logic [NREQ*W-1:0] req_rs1,
    output logic [NREQ-1:0]   req_accepted,
    output logic [NREQ-1:0]   req_done,
    output logic [W-1:0]      req_rd,
    output logic              busy,
    output logic              unit_order,
    output logic [W-1:0]      unit_rs1,
    input  logic              unit_accepted,
    input  logic              unit_done,
    input  logic [W-1:0]      unit_rd
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_n;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_gnt;
    logic [W-1:0]      r_op;
    logic [W-1:0]      r_rd;
    logic [NREQ-1:0]   r_done;

    logic [PW-1:0]     w_win;
    logic [PW-1:0]     w_idx;
    logic [PW:0]       w_sum;
    logic              w_any;
    logic              w_grant;
    logic              w_capture;

    // Round-robin scan starting at r_ptr. The loop runs from the farthest
    // offset back to the nearest so the last hit is the first in scan order.
    // NREQ need not be a power of two, so the wrap is an explicit compare.
    always_comb begin
        w_any = 1'b0;
        w_win = r_ptr;
        w_sum = '0;
        w_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (PW + 1)'(k);
            if (w_sum >= (PW + 1)'(NREQ)) begin
                w_sum = w_sum - (PW + 1)'(NREQ);
            end
            w_idx = w_sum[PW-1:0];
            if (req_order[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // Next-state logic and the outputs decoded directly from state.
    always_comb begin
        w_state_n    = r_state;
        w_grant      = 1'b0;
        w_capture    = 1'b0;
        req_accepted = '0;
        unit_order   = 1'b0;
        unit_rs1     = '0;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant      = 1'b1;
                    req_accepted = NREQ'(1) << w_win;
                    w_state_n    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                unit_order = 1'b1;
                unit_rs1   = r_op;
                if (unit_accepted && unit_done) begin
                    w_capture = 1'b1;
                    w_state_n = S_RESP;
                end else if (unit_accepted) begin
                    w_state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (unit_done) begin
                    w_capture = 1'b1;
                    w_state_n = S_RESP;
                end
            end
            S_RESP: begin
                w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Grant/operand latch, result capture, done pulse and pointer advance.
    // Everything is cleared on reset so an abandoned transaction leaves no trace.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr  <= '0;
            r_gnt  <= '0;
            r_op   <= '0;
            r_rd   <= '0;
            r_done <= '0;
        end else begin
            if (w_grant) begin
                r_gnt <= w_win;
                r_op  <= req_rs1[w_win*W +: W];
            end
            if (w_capture) begin
                r_rd <= unit_rd;
            end
            r_done <= w_capture ? (NREQ'(1) << r_gnt) : '0;
            if (r_state == S_RESP) begin
                r_ptr <= (r_gnt == PW'(NREQ - 1)) ? '0 : r_gnt + PW'(1);
            end
        end
    end

    assign req_done = r_done;
    assign req_rd   = r_rd;

endmodule
